// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding and default timing,
// so that the transmitter and a matching receiver can use the same values.
package uart_pkg;

    localparam int STATE_W = 5;

    typedef logic [STATE_W-1:0] state_t;

    // One-hot encodings. Any other value is treated as illegal and recovers to idle.
    localparam state_t S_IDLE   = 5'b00001;
    localparam state_t S_START  = 5'b00010;
    localparam state_t S_DATA   = 5'b00100;
    localparam state_t S_PARITY = 5'b01000;
    localparam state_t S_STOP   = 5'b10000;

    // 50 MHz / 115200 baud, rounded.
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_DATA_BITS    = 8;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte moves on a rising edge where tx_valid and tx_ready are both high.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface : uart_tx_if

// File: rtl/uart_baud_gen.sv
// Baud counter: counts clk cycles within one serial bit and pulses tick on
// the last cycle of each bit. clear restarts the bit period from zero.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST_CNT);

    // Next count: restart on clear or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional even
// parity bit, one stop bit. The serial output is driven from a register.
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   s_if,
    output logic       tx,
    output logic       busy
);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 baud_clear;
    logic                 baud_tick;
    logic                 transfer;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign s_if.tx_ready = (state_q == S_IDLE);
    assign busy          = ~s_if.tx_ready;
    assign transfer      = s_if.tx_valid && s_if.tx_ready;
    assign tx            = tx_q;

    // The bit period restarts on every state change; idle keeps it parked at zero
    // so the start bit always gets a full CLKS_PER_BIT cycles.
    assign baud_clear = (state_d != state_q) || (state_q == S_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    // Next-state logic; tx_d is derived from the next state so the line
    // changes on the same edge as the state, keeping tx fully registered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    state_d   = S_START;
                    shift_d   = s_if.tx_data;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^s_if.tx_data;
`endif
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = AFTER_DATA;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (baud_tick) begin
                    state_d = S_STOP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                // Non-one-hot value: recover to idle with the line high.
                state_d   = S_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // State, datapath and line registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end
endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, DATA_BITS=8.
// Cycle numbering: the transfer edge ends cycle 0; cycle k is sampled 1 time
// unit after the k-th following rising edge.
module tb_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk;
    logic rst;
    logic tx;
    logic busy;

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    logic last_parity;

    uart_tx_if #(.DATA_BITS(8)) u_if ();

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s_if(u_if.slave),
        .tx  (tx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        cmp_cnt++;
        assert (got === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer byte d in the current cycle and check the whole frame on tx.
    // At cycle mid_cyc tx_data is replaced by mid_data; if keep_valid is 0
    // tx_valid is also pulsed there to show it is ignored mid-frame.
    // Returns in the first idle cycle after the stop bit.
    task automatic send_check(input logic [7:0] d, input logic [7:0] mid_data,
                              input int mid_cyc, input bit keep_valid);
        logic [10:0] fb;
        logic [7:0]  decoded;
        int          bi;
        fb      = '1;
        fb[0]   = 1'b0;
        fb[8:1] = d;
`ifdef UART_TX_PARITY_EN
        fb[9]   = ^d;
`endif
        decoded = '0;
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        next_cycle();
        if (!keep_valid) u_if.tx_valid = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            bi = (k - 1) / CPB;
            chk($sformatf("tx_bit c%0d", k), {7'd0, tx}, {7'd0, fb[bi]});
            chk($sformatf("busy c%0d", k), {7'd0, u_if.tx_ready, busy}, 8'd1);
            if ((k - 1) % CPB == 1) begin
                if (bi >= 1 && bi <= 8) decoded[bi-1] = tx;
                if (bi == 9 && NBITS == 11) last_parity = tx;
            end
            if (k == mid_cyc) begin
                u_if.tx_data = mid_data;
                if (!keep_valid) u_if.tx_valid = 1'b1;
            end
            if (k == mid_cyc + 2 && !keep_valid) u_if.tx_valid = 1'b0;
            next_cycle();
        end
        chk("decoded", decoded, d);
        chk("ready_after", {6'd0, u_if.tx_ready, tx}, 8'd3);
        $display("frame data=%02h decoded=%02h len=%0d", d, decoded, FRAME);
    endtask

    initial begin
        logic [9:0] seq55;
        rst           = 1'b1;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        repeat (3) next_cycle();
        chk("rst_tx", {7'd0, tx}, 8'd1);
        chk("rst_ready", {7'd0, u_if.tx_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);

        // Idle after reset release.
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            next_cycle();
            chk("idle", {5'd0, tx, u_if.tx_ready, busy}, 8'b110);
        end
        $display("idle 100 cycles checked");

        // 0x55 with a hand-written bit sequence (start, data LSB first, stop).
        seq55 = 10'b10_1010_1010;
        u_if.tx_data  = 8'h55;
        u_if.tx_valid = 1'b1;
        next_cycle();
        u_if.tx_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if ((k - 1) / CPB < 9 || NBITS == 10)
                chk($sformatf("f55 c%0d", k), {7'd0, tx}, {7'd0, seq55[(k-1)/CPB]});
            chk($sformatf("f55_rdy c%0d", k), {7'd0, u_if.tx_ready}, 8'd0);
            next_cycle();
        end
        if (NBITS == 11) repeat (CPB) next_cycle();
        chk("f55_rdy_41", {7'd0, u_if.tx_ready}, 8'd1);
        $display("frame data=55 sequence checked");

        // Back-to-back with tx_valid held high: 0xA5 then 0x3C, one idle cycle between.
        send_check(8'hA5, 8'h3C, 5, 1'b1);
        send_check(8'h3C, 8'h3C, 0, 1'b0);

        // Data and valid changes mid-frame are ignored.
        send_check(8'hC3, 8'h00, 10, 1'b0);

`ifdef UART_TX_PARITY_EN
        send_check(8'h07, 8'h07, 0, 1'b0);
        chk("parity_07", {7'd0, last_parity}, 8'd1);
        send_check(8'h03, 8'h03, 0, 1'b0);
        chk("parity_03", {7'd0, last_parity}, 8'd0);
`endif

        // 0xFF aborted by reset on cycle 14.
        u_if.tx_data  = 8'hFF;
        u_if.tx_valid = 1'b1;
        next_cycle();
        u_if.tx_valid = 1'b0;
        for (int k = 1; k < 14; k++) begin
            chk($sformatf("fFF c%0d", k), {7'd0, tx}, (k <= 4) ? 8'd0 : 8'd1);
            next_cycle();
        end
        chk("fFF_busy14", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("abort_c15", {5'd0, tx, u_if.tx_ready, busy}, 8'b110);
        for (int i = 0; i < 60; i++) begin
            next_cycle();
            chk("abort_quiet", {5'd0, tx, u_if.tx_ready, busy}, 8'b110);
        end
        $display("frame data=ff aborted by reset");

        // Reset wins over a simultaneous offer of 0x00.
        u_if.tx_data  = 8'h00;
        u_if.tx_valid = 1'b1;
        rst           = 1'b1;
        next_cycle();
        rst           = 1'b0;
        u_if.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rst_prio", {5'd0, tx, u_if.tx_ready, busy}, 8'b110);
            next_cycle();
        end
        $display("reset priority over valid checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (legal minimum 2).
REQ-003 Parameter DATA_BITS, default 8, data bits per frame (legal range 5..8).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 tx_data  input  DATA_BITS  byte to send; LSB is sent first.
REQ-007 tx_valid  input  1  a byte is offered on tx_data.
REQ-008 tx_ready  output  1  the block can accept a byte this cycle.
REQ-009 tx  output  1  serial line; idle level is high.
REQ-010 busy  output  1  a frame is in progress.

Function
REQ-011 The state register SHALL be one-hot: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
REQ-012 Handshake: a transfer occurs on a rising edge where tx_valid and tx_ready are both 1; tx_data SHALL be captured into a shift register on that edge.
REQ-013 tx_ready SHALL be 1 only in S_IDLE; busy SHALL be the inverse of tx_ready.
REQ-014 S_IDLE->S_START on transfer; tx SHALL go low on the cycle after the transfer edge (latency 1).
REQ-015 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that clears on every state change.
REQ-016 S_START->S_DATA after one bit time; S_DATA SHALL shift out DATA_BITS bits LSB-first, counted by a bit counter 0..DATA_BITS-1.
REQ-017 On the last data bit, S_DATA SHALL go to S_PARITY if parity is compiled in, otherwise to S_STOP.
REQ-018 S_STOP SHALL drive tx high for one bit time and then go to S_IDLE.
REQ-019 Frame length SHALL be (DATA_BITS+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is compiled in.
REQ-020 Back-to-back: a transfer in the first S_IDLE cycle after a stop bit SHALL start the next start bit one cycle later, so there is exactly one idle-high cycle between frames.
REQ-021 tx_data and tx_valid changes during a frame SHALL be ignored and SHALL NOT alter the frame in progress.
REQ-022 tx SHALL be registered, with no combinational path from any input to tx.
REQ-023 An illegal (non-one-hot) state SHALL return to S_IDLE on the next edge with tx high.

Reset
REQ-024 While rst is 1: state=S_IDLE, tx=1, tx_ready=1, busy=0, baud and bit counters=0, shift register=0.
REQ-025 rst asserted mid-frame SHALL abort the frame, and tx SHALL be high on the edge after rst; no partial byte is resumed.
REQ-026 rst takes priority over a simultaneous tx_valid, and that byte SHALL NOT be accepted.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, S_PARITY SHALL send one even-parity bit (XOR of the captured data bits) for one bit time between the last data bit and the stop bit.
REQ-028 Without UART_TX_PARITY_EN, S_PARITY SHALL never be entered and the frame SHALL be start + data + stop.

Structure
REQ-029 Shared package uart_pkg SHALL hold the one-hot state localparams S_IDLE..S_STOP and the default CLKS_PER_BIT, for reuse by the receiver.
REQ-030 Sub-module uart_baud_gen SHALL implement the baud counter, with inputs clk, rst, clear and output tick pulsing once per CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-031 Reset release, no valid -> tx=1, tx_ready=1 and busy=0 held for 100 cycles.
REQ-032 Send 0x55 -> tx bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total; tx_ready high again on cycle 41.
REQ-033 tx_valid held high with 0xA5 then 0x3C -> two frames with exactly one idle cycle between them; decoded bytes are 0xA5 and 0x3C.
REQ-034 Frame 0xFF, rst pulsed on cycle 14 -> tx=1 on cycle 15, tx_ready=1, and no further transitions on tx.
REQ-035 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 and frame length 44 cycles; send 0x03 -> parity bit 0.
REQ-036 tx_data changed to 0x00 mid-frame of 0xC3 -> line still carries 0xC3.
